fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arb.sv | 168 ++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared defaults, widths and FSM state type for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 4;
  localparam int N_REQ_DEF = 4;
  localparam int PTR_W     = $clog2(DEPTH_DEF) + 1;

  typedef enum logic {
    NORMAL = 1'b0,
    FLUSH  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority pick: first eligible slot at or after start wins.
module rr_pick #(
  parameter int N  = 5,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  win,
  output logic          valid
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(start) + i) % N);
      if (!valid && elig[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting N_REQ writers and one reader access to a FIFO, with flush drain.
// Define FIFO_ARB_RDPRIO_EN to give the reader absolute priority over the writers.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         gnt,
  input  logic                     rd_req,
  output logic                     rd_gnt,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     fifo_wr_en,
  output logic                     fifo_rd_en,
  output logic [WIDTH-1:0]         fifo_din,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RR_W  = $clog2(N_REQ + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  arb_state_e        state_q, state_d;
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              rd_gnt_q, rd_gnt_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic              done_q, done_d;

  logic              arb_en;
  logic [N_REQ-1:0]  wr_elig;
  logic              rd_elig;
  logic [N_REQ-1:0]  wr_win;
  logic              rd_win;
  logic              ptr_adv;
  logic [RR_W-1:0]   ptr_nxt;
  logic [RR_W-1:0]   win_idx;

  // A flush request blocks arbitration on the very edge it is sampled.
  assign arb_en  = (state_q == NORMAL) && !flush;
  assign wr_elig = (arb_en && count_q < FULL) ? (req & ~gnt_q) : '0;
  assign rd_elig = arb_en && rd_req && !rd_gnt_q && (count_q != '0);

`ifdef FIFO_ARB_RDPRIO_EN
  logic [N_REQ-1:0] win;
  logic             win_vld;

  rr_pick #(.N(N_REQ), .SW(RR_W)) u_pick (
    .elig  (wr_elig),
    .start (rr_ptr_q),
    .win   (win),
    .valid (win_vld)
  );

  always_comb begin
    rd_win  = rd_elig;
    wr_win  = rd_elig ? '0 : win;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win[i]) win_idx = RR_W'(i);
    ptr_adv = win_vld && !rd_elig;
    ptr_nxt = (win_idx == RR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end
`else
  logic [N_REQ:0] win;
  logic           win_vld;

  rr_pick #(.N(N_REQ + 1), .SW(RR_W)) u_pick (
    .elig  ({rd_elig, wr_elig}),
    .start (rr_ptr_q),
    .win   (win),
    .valid (win_vld)
  );

  always_comb begin
    rd_win  = win[N_REQ];
    wr_win  = win[N_REQ-1:0];
    win_idx = '0;
    for (int i = 0; i <= N_REQ; i++)
      if (win[i]) win_idx = RR_W'(i);
    ptr_adv = win_vld;
    ptr_nxt = (win_idx == RR_W'(N_REQ)) ? '0 : win_idx + 1'b1;
  end
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    gnt_d    = '0;
    rd_gnt_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    din_d    = '0;
    done_d   = 1'b0;
    case (state_q)
      NORMAL: begin
        if (flush) begin
          state_d = FLUSH;
        end else begin
          gnt_d    = wr_win;
          wr_en_d  = |wr_win;
          rd_gnt_d = rd_win;
          rd_en_d  = rd_win;
          for (int i = 0; i < N_REQ; i++)
            if (wr_win[i]) din_d = din[i*WIDTH +: WIDTH];
          if (ptr_adv) rr_ptr_d = ptr_nxt;
          if (|wr_win)     count_d = count_q + 1'b1;
          else if (rd_win) count_d = count_q - 1'b1;
        end
      end
      FLUSH: begin
        // Drained words are discarded, so the reader never sees a grant here.
        if (count_q != '0) begin
          rd_en_d = 1'b1;
          count_d = count_q - 1'b1;
        end else begin
          state_d = NORMAL;
          done_d  = 1'b1;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      rr_ptr_q <= '0;
      count_q  <= '0;
      gnt_q    <= '0;
      rd_gnt_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      din_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      gnt_q    <= gnt_d;
      rd_gnt_q <= rd_gnt_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      din_q    <= din_d;
      done_q   <= done_d;
    end
  end

  assign gnt        = gnt_q;
  assign rd_gnt     = rd_gnt_q;
  assign fifo_wr_en = wr_en_q;
  assign fifo_rd_en = rd_en_q;
  assign fifo_din   = din_q;
  assign flush_done = done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed-vector bench for fifo_wr_arb in its default (round-robin reader) build.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] din = '0;
  logic [3:0]  gnt;
  logic        rd_req = 1'b0;
  logic        rd_gnt;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        fifo_wr_en;
  logic        fifo_rd_en;
  logic [3:0]  fifo_din;
  logic [4:0]  count;

  int vec  = 0;
  int errs = 0;

  fifo_wr_arb #(.DEPTH(16), .WIDTH(4), .N_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .rd_req     (rd_req),
    .rd_gnt     (rd_gnt),
    .flush      (flush),
    .flush_done (flush_done),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_din   (fifo_din),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Packs {gnt, rd_gnt, wr_en, rd_en, flush_done, din, count}; din only matters on a write.
  function automatic logic [16:0] mk(input logic [3:0] g, input logic rg, input logic we,
                                     input logic re, input logic fd, input logic [3:0] d,
                                     input logic [4:0] c);
    return {g, rg, we, re, fd, (we ? d : 4'h0), c};
  endfunction

  function automatic logic [16:0] snap();
    return {gnt, rd_gnt, fifo_wr_en, fifo_rd_en, flush_done,
            (fifo_wr_en ? fifo_din : 4'h0), count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    din    = '0;
    rd_req = 1'b0;
    flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    do_reset();
    obs = {gnt, rd_gnt, fifo_wr_en, fifo_rd_en, flush_done, fifo_din, count};
    if (obs !== 17'h0) begin
      $display("FAIL reset got=%h exp=%h", obs, 17'h0); errs++;
    end
    vec++;
  endtask

  task automatic test_round_robin();
    logic [16:0] obs, exp;
    do_reset();
    req = 4'b1111;
    din = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int k = 0; k < 4; k++) begin
      step();
      obs = snap();
      exp = mk(4'(1 << k), 1'b0, 1'b1, 1'b0, 1'b0, 4'(k + 1), 5'(k + 1));
      if (obs !== exp) begin
        $display("FAIL rr[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
  endtask

  task automatic test_single_req();
    logic [16:0] obs, exp;
    do_reset();
    req = 4'b0100;
    din = 16'h0700;
    for (int k = 0; k < 8; k++) begin
      step();
      obs = snap();
      if (k % 2 == 0) exp = mk(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 5'(k / 2 + 1));
      else            exp = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'(k / 2 + 1));
      if (obs !== exp) begin
        $display("FAIL single[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
  endtask

  task automatic test_full();
    logic [16:0] obs, exp;
    do_reset();
    req = 4'b1111;
    din = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int k = 0; k < 16; k++) begin
      step();
      obs = snap();
      exp = mk(4'(1 << (k % 4)), 1'b0, 1'b1, 1'b0, 1'b0, 4'(k % 4 + 1), 5'(k + 1));
      if (obs !== exp) begin
        $display("FAIL fill[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      obs = snap();
      exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd16);
      if (obs !== exp) begin
        $display("FAIL full_hold[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    obs = snap();
    exp = mk(4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd15);
    if (obs !== exp) begin
      $display("FAIL full_read got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
    step();
    obs = snap();
    exp = mk(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 5'd16);
    if (obs !== exp) begin
      $display("FAIL refill got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
    for (int k = 0; k < 3; k++) begin
      step();
      obs = snap();
      exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd16);
      if (obs !== exp) begin
        $display("FAIL refull[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
  endtask

  task automatic test_empty_read();
    logic [16:0] obs, exp;
    do_reset();
    rd_req = 1'b1;
    exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      obs = snap();
      if (obs !== exp) begin
        $display("FAIL empty_rd[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
    rd_req = 1'b0;
  endtask

  task automatic test_flush();
    logic [16:0] obs, exp;
    do_reset();
    req = 4'b1111;
    din = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int k = 0; k < 5; k++) begin
      step();
      obs = snap();
      exp = mk(4'(1 << (k % 4)), 1'b0, 1'b1, 1'b0, 1'b0, 4'(k % 4 + 1), 5'(k + 1));
      if (obs !== exp) begin
        $display("FAIL fl_fill[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    obs = snap();
    exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd5);
    if (obs !== exp) begin
      $display("FAIL fl_enter got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) flush = 1'b1;
      step();
      obs = snap();
      exp = mk(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5'(4 - k));
      if (obs !== exp) begin
        $display("FAIL fl_drain[%0d] got=%h exp=%h", k, obs, exp); errs++;
      end
      vec++;
    end
    flush = 1'b0;
    step();
    obs = snap();
    exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0);
    if (obs !== exp) begin
      $display("FAIL fl_done got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
    step();
    obs = snap();
    exp = mk(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 5'd1);
    if (obs !== exp) begin
      $display("FAIL fl_resume got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
  endtask

  task automatic test_flush_empty();
    logic [16:0] obs, exp;
    do_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    obs = snap();
    exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
    if (obs !== exp) begin
      $display("FAIL fle_enter got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
    step();
    obs = snap();
    exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd0);
    if (obs !== exp) begin
      $display("FAIL fle_done got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
    step();
    obs = snap();
    exp = mk(4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
    if (obs !== exp) begin
      $display("FAIL fle_after got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
  endtask

  task automatic test_reset_mid();
    logic [16:0] obs, exp;
    do_reset();
    req = 4'b1111;
    din = {4'd4, 4'd3, 4'd2, 4'd1};
    step();
    step();
    obs = snap();
    exp = mk(4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 5'd2);
    if (obs !== exp) begin
      $display("FAIL mid_pre got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
    #2 rst_n = 1'b0;
    #1;
    obs = {gnt, rd_gnt, fifo_wr_en, fifo_rd_en, flush_done, fifo_din, count};
    if (obs !== 17'h0) begin
      $display("FAIL mid_async got=%h exp=%h", obs, 17'h0); errs++;
    end
    vec++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    obs = snap();
    exp = mk(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 5'd1);
    if (obs !== exp) begin
      $display("FAIL mid_first got=%h exp=%h", obs, exp); errs++;
    end
    vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_req();
    test_full();
    test_empty_read();
    test_flush();
    test_flush_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
